sys_sequencer: RTL

SYS_SEQUENCER -- requirements
Module: sys_sequencer

---
 rtl/sys_seq_pkg.sv | 17 +
 rtl/sys_seq_regs.sv | 101 ++++++++++
 rtl/sys_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sys_seq_pkg.sv
// Shared constants and types for the systolic-array sequencer.
package sys_seq_pkg;
  localparam int CNT_W = 16;

  localparam logic [15:0] ADDR_START    = 16'hFFF0;
  localparam logic [15:0] ADDR_MAX_CNTR = 16'hFFF1;
  localparam logic [15:0] ADDR_RUN_CNTR = 16'hFFF2;
  localparam logic [15:0] ADDR_STATUS   = 16'hFFF3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/sys_seq_regs.sv
// ibus decode, configuration registers and registered read mux.
// Optional interrupt mask/irq guarded by macro SYS_SEQ_IRQ_EN.
module sys_seq_regs
  import sys_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [15:0]      ibus_wadr,
  input  logic [15:0]      ibus_wdata,
  input  logic             ren,
  input  logic [15:0]      ibus_radr,
  output logic [15:0]      ibus_rdata,
  input  logic             busy,
  input  logic             done_set,
  output logic             start,
  output logic [CNT_W-1:0] max_cntr,
  output logic [CNT_W-1:0] run_cntr
`ifdef SYS_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             done_q, done_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             mask_bit;
`ifdef SYS_SEQ_IRQ_EN
  logic             mask_q, mask_d;
  assign mask_bit = mask_q;
  assign irq      = done_q & ~mask_q;
`else
  assign mask_bit = 1'b0;
`endif

  // Write decode: START and counter writes are locked out while a run is active.
  always_comb begin
    max_d = max_q;
    run_d = run_q;
    done_d = done_q;
    start = 1'b0;
`ifdef SYS_SEQ_IRQ_EN
    mask_d = mask_q;
`endif
    if (wen && !busy) begin
      case (ibus_wadr)
        ADDR_START:    start = 1'b1;
        ADDR_MAX_CNTR: max_d = ibus_wdata;
        ADDR_RUN_CNTR: run_d = ibus_wdata;
        default: ;
      endcase
    end
    if (start) done_d = 1'b0;
    if (wen && ibus_wadr == ADDR_STATUS) begin
      done_d = 1'b0;
`ifdef SYS_SEQ_IRQ_EN
      mask_d = ibus_wdata[2];
`endif
    end
    if (done_set) done_d = 1'b1;
  end

  // Read mux: unowned addresses and idle cycles return 0 so the parent can OR.
  always_comb begin
    rdata_d = 16'h0000;
    if (ren) begin
      case (ibus_radr)
        ADDR_MAX_CNTR: rdata_d = max_q;
        ADDR_RUN_CNTR: rdata_d = run_q;
        ADDR_STATUS:   rdata_d = {13'b0, mask_bit, done_q, busy};
        default:       rdata_d = 16'h0000;
      endcase
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q   <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= 16'h0000;
`ifdef SYS_SEQ_IRQ_EN
      mask_q  <= 1'b0;
`endif
    end else begin
      max_q   <= max_d;
      run_q   <= run_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
`ifdef SYS_SEQ_IRQ_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign ibus_rdata = rdata_q;
  assign max_cntr   = max_q;
  assign run_cntr   = run_q;
endmodule

// File: rtl/sys_sequencer.sv
// Systolic-array sequencer: CLEAR -> FEED -> DRAIN -> DONE run control,
// with lane-1 buffer read skewed one cycle behind lane 0.
// Optional irq output guarded by macro SYS_SEQ_IRQ_EN.
module sys_sequencer
  import sys_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [15:0] ibus_wadr,
  input  logic [15:0] ibus_wdata,
  input  logic        ren,
  input  logic [15:0] ibus_radr,
  output logic [15:0] ibus_rdata,
  output logic        buf_ren_0,
  output logic [15:0] buf_radr_0,
  output logic        buf_ren_1,
  output logic [15:0] buf_radr_1,
  output logic        pe_clr,
  output logic        pe_en,
  output logic        res_capture,
  output logic        busy
`ifdef SYS_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ren1_q, ren1_d;
  logic [15:0]      radr1_q, radr1_d;
  logic             start;
  logic [CNT_W-1:0] max_cntr, run_cntr;

  sys_seq_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .ibus_wadr  (ibus_wadr),
    .ibus_wdata (ibus_wdata),
    .ren        (ren),
    .ibus_radr  (ibus_radr),
    .ibus_rdata (ibus_rdata),
    .busy       (busy),
    .done_set   (res_capture),
    .start      (start),
    .max_cntr   (max_cntr),
    .run_cntr   (run_cntr)
`ifdef SYS_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // State, phase counter and lane-1 skew registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ren1_q  <= 1'b0;
      radr1_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren1_q  <= ren1_d;
      radr1_q <= radr1_d;
    end
  end

  // Next state; the counter indexes FEED addresses then counts DRAIN cycles.
  // Comparing against the terminal value (not overflow) lets MAX=0xFFFF run 65536 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (cnt_q == max_cntr) begin
          cnt_d   = '0;
          state_d = (run_cntr == '0) ? ST_DONE : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == run_cntr - 1'b1) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    pe_clr      = (state_q == ST_CLEAR);
    pe_en       = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    res_capture = (state_q == ST_DONE);
    buf_ren_0   = (state_q == ST_FEED);
    buf_radr_0  = (state_q == ST_FEED) ? cnt_q : 16'h0000;
    ren1_d      = buf_ren_0;
    radr1_d     = buf_radr_0;
  end

  assign buf_ren_1  = ren1_q;
  assign buf_radr_1 = radr1_q;
endmodule
